// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared constants for the carry-look-ahead operand stage and its FIFO.
//   CLA_N          default operand width
//   CLA_SLICE_W    width of one carry-look-ahead slice in the downstream adder
//   CLA_FIFO_DEPTH depth of the operand FIFO
//   CLA_CNT_W      width of the FIFO occupancy counter (holds 0..CLA_FIFO_DEPTH)
//   CLA_TXN_W      width of the optional output-transfer counter
// Helper:
//   cla_ptr_next   advance a FIFO pointer, wrapping modulo the FIFO depth
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int CLA_N          = 16;
    localparam int CLA_SLICE_W    = 4;
    localparam int CLA_FIFO_DEPTH = 2;
    localparam int CLA_CNT_W      = 2;
    localparam int CLA_TXN_W      = 16;

    // With a depth of two a pointer is one bit, so advancing is a toggle.
    function automatic logic cla_ptr_next(input logic ptr);
        return ~ptr;
    endfunction

endpackage

// File: rtl/cla_operand_fifo.sv
// -----------------------------------------------------------------------------
// cla_operand_fifo
// Two-entry in-order FIFO holding packed operand pairs for the CLA stage.
// The head entry is presented combinationally from the storage registers and
// forced to zero while the FIFO is empty.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (clears pointers, count, data)
//   push_i   in   write wdata_i (ignored when full)
//   wdata_i  in   W-bit entry to write
//   pop_i    in   remove the head entry (ignored when empty)
//   rdata_o  out  head entry, zero when empty
//   empty_o  out  FIFO holds no entries
//   full_o   out  FIFO holds CLA_FIFO_DEPTH entries
// -----------------------------------------------------------------------------
module cla_operand_fifo
    import cla_pkg::*;
#(
    parameter int W = 2 * CLA_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         empty_o,
    output logic         full_o
);

    logic [W-1:0]           mem_q [0:CLA_FIFO_DEPTH-1];
    logic                   wr_ptr_q;
    logic                   wr_ptr_d;
    logic                   rd_ptr_q;
    logic                   rd_ptr_d;
    logic [CLA_CNT_W-1:0]   count_q;
    logic [CLA_CNT_W-1:0]   count_d;
    logic                   push_ok_s;
    logic                   pop_ok_s;

    assign empty_o   = (count_q == CLA_CNT_W'(0));
    assign full_o    = (count_q == CLA_CNT_W'(CLA_FIFO_DEPTH));
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = cla_ptr_next(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = cla_ptr_next(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CLA_CNT_W'(1);
            2'b01:   count_d = count_q - CLA_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, occupancy and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= CLA_CNT_W'(0);
            for (int i = 0; i < CLA_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

    // Head presentation; an empty FIFO shows zero rather than a stale entry.
    always_comb begin
        if (empty_o) begin
            rdata_o = '0;
        end else begin
            rdata_o = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/cla_operand_stage.sv
// -----------------------------------------------------------------------------
// cla_operand_stage
// Buffers operand pairs in a 2-entry FIFO, presents the head pair to an
// external combinational carry-look-ahead adder and registers the adder
// result behind a valid/ready output handshake with a sticky carry-out flag.
// Parameters:
//   N  operand width, a multiple of 4
//   M  number of 4-bit slices in the downstream adder, equal to N/4
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair offered
//   in_ready   out  stage can accept a pair (FIFO not full)
//   in_a/in_b  in   N-bit operands
//   add_a/b    out  head operands to the adder, zero when FIFO empty
//   add_sum    in   N+1-bit adder result, bit N is carry-out
//   out_valid  out  registered result available
//   out_ready  in   consumer accepts the result
//   out_sum    out  registered N+1-bit result
//   out_ovf    out  sticky carry-out flag, cleared only by reset
//   txn_count  out  16-bit output-transfer counter, present only when the
//                   macro CLA_STAGE_TXN_COUNT_EN is defined
// -----------------------------------------------------------------------------
module cla_operand_stage
    import cla_pkg::*;
#(
    parameter int N = CLA_N,
    parameter int M = N / CLA_SLICE_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_a,
    input  logic [N-1:0]         in_b,
    output logic [N-1:0]         add_a,
    output logic [N-1:0]         add_b,
    input  logic [N:0]           add_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N:0]           out_sum,
    output logic                 out_ovf
`ifdef CLA_STAGE_TXN_COUNT_EN
    ,
    output logic [CLA_TXN_W-1:0] txn_count
`endif
);

    // Operand width as seen by the adder slices. Every path below is sized
    // from it, so a parameter set with M != N/4 shows up as width mismatches.
    localparam int OP_W = M * CLA_SLICE_W;

    logic                  fifo_push_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic [2*OP_W-1:0]     fifo_rdata_s;
    logic                  issue_s;

    logic                  out_valid_q;
    logic                  out_valid_d;
    logic [N:0]            out_sum_q;
    logic [N:0]            out_sum_d;
    logic                  out_ovf_q;
    logic                  out_ovf_d;

    // in_ready comes straight from the registered FIFO count, never from in_valid.
    assign in_ready    = ~fifo_full_s;
    assign fifo_push_s = in_valid & ~fifo_full_s;

    // A pair pushed into an empty FIFO is not issued on the same edge because
    // fifo_empty_s still reflects the pre-edge occupancy.
    assign issue_s = ~fifo_empty_s & (~out_valid_q | out_ready);

    cla_operand_fifo #(
        .W (2 * OP_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push_s),
        .wdata_i ({in_a, in_b}),
        .pop_i   (issue_s),
        .rdata_o (fifo_rdata_s),
        .empty_o (fifo_empty_s),
        .full_o  (fifo_full_s)
    );

    assign add_a = fifo_rdata_s[2*OP_W-1:OP_W];
    assign add_b = fifo_rdata_s[OP_W-1:0];

    // Result register next-state: load on issue, drop valid once consumed.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        if (issue_s) begin
            out_valid_d = 1'b1;
            out_sum_d   = add_sum;
            out_ovf_d   = out_ovf_q | add_sum[N];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Result, valid and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

`ifdef CLA_STAGE_TXN_COUNT_EN
    logic [CLA_TXN_W-1:0] txn_count_q;
    logic [CLA_TXN_W-1:0] txn_count_d;

    // Count completed output transfers; wraps naturally at the counter width.
    always_comb begin
        if (out_valid_q & out_ready) begin
            txn_count_d = txn_count_q + CLA_TXN_W'(1);
        end else begin
            txn_count_d = txn_count_q;
        end
    end

    // Transfer counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count_q <= CLA_TXN_W'(0);
        end else begin
            txn_count_q <= txn_count_d;
        end
    end

    assign txn_count = txn_count_q;
`endif

endmodule

// File: doc/cla_operand_stage.md
CLA_OPERAND_STAGE -- requirements
Module: cla_operand_stage

Interface
REQ-001 Parameter N, default 16: operand width; SHALL be a multiple of 4.
REQ-002 Parameter M, default N/4: number of 4-bit CLA slices in the downstream adder; SHALL equal N/4.
REQ-003 Ports (clock and reset first):
- clk  input  1  single clock; all state SHALL change on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  stage can accept a pair.
- in_a, in_b  input  N  operands.
- add_a, add_b  output  N  operands presented to the combinational carry-look-ahead adder.
- add_sum  input  N+1  adder result; bit N is carry-out.
- out_valid  output  1  registered result available.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  N+1  registered result.
- out_ovf  output  1  sticky carry-out flag.

Function
REQ-004 Input transfer SHALL occur on a rising edge where in_valid & in_ready.
REQ-005 Accepted pairs SHALL enter a 2-entry FIFO in order; in_ready SHALL be 1 iff the FIFO holds fewer than 2 entries. It SHALL NOT depend combinationally on in_valid.
REQ-006 add_a/add_b SHALL be driven from the FIFO head register. They SHALL be 0 when the FIFO is empty.
REQ-007 Issue condition: FIFO non-empty AND (out_valid==0 OR out_ready==1).
- On issue, the head SHALL be popped.
- add_sum SHALL be captured into out_sum on the same edge.
- out_valid SHALL be 1 after that edge.
REQ-008 Latency: a pair accepted at edge k SHALL produce out_valid=1 after edge k+1 when the output is free. Sustained throughput SHALL be one result per cycle with out_ready held 1.
REQ-009 out_valid SHALL clear after an edge where out_valid & out_ready and no issue occurs.
REQ-010 While out_valid & !out_ready, out_sum SHALL hold stable.
REQ-011 A simultaneous push and pop with the FIFO full SHALL NOT occur, because in_ready=0 when full. A push and pop with 1 entry SHALL leave occupancy at 1 with order preserved.
REQ-012 A push into an empty FIFO SHALL NOT be issued on the same edge. The head becomes visible on the next cycle.
REQ-013 out_ovf SHALL set when a captured add_sum[N]=1. It SHALL remain set until reset.
REQ-014 Pointers SHALL wrap modulo 2. Occupancy SHALL be tracked with a 2-bit count (0..2).

Reset
REQ-015 rst_n low SHALL immediately set:
- FIFO count=0 and pointers=0;
- in_ready=1;
- out_valid=0;
- out_sum=0;
- out_ovf=0;
- add_a=add_b=0.
REQ-016 Reset asserted mid-transfer SHALL discard all buffered pairs and the held result. The first edge after deassertion SHALL behave as from the empty state.

Configuration
REQ-017 Macro CLA_STAGE_TXN_COUNT_EN:
- When defined, the module SHALL add output txn_count (16 bits). It SHALL increment by 1 on every output transfer (out_valid & out_ready), wrap from 0xFFFF to 0, and reset to 0.
- When undefined, the port and counter SHALL be absent, with no other behavioural change.

Structure
REQ-018 A shared package cla_pkg SHALL hold:
- the default width constants (N=16, slice width 4);
- the FIFO depth constant (2);
- the count width constant.
REQ-019 The FIFO SHALL be one sub-module, cla_operand_fifo (parameterised width 2N, depth 2). All handshake and result logic SHALL remain in cla_operand_stage.

Verification
REQ-020 The bench SHALL connect add_a/add_b/add_sum to the team's 16-bit carry-look-ahead adder (N=16). It SHALL cover:
- Single pair 0x1234+0x0001, out_ready=1 -> out_valid after edge k+1, out_sum=0x01235, out_ovf=0.
- 0xFFFF+0x0001 -> out_sum=0x10000, out_ovf=1. A following 0x0001+0x0001 gives out_sum=0x00002 with out_ovf still 1.
- out_ready=0, push three pairs (1+1, 2+2, 3+3):
  - in_ready drops after the third is accepted (result reg plus 2 FIFO entries);
  - out_sum holds 0x00002;
  - releasing out_ready yields 2, 4, 6 in order on consecutive cycles.
- Back-to-back stream of 8 pairs with out_ready=1 -> 8 results on 8 consecutive cycles, in_ready constantly 1.
- rst_n pulsed low while 2 entries are buffered and out_valid=1 -> out_valid=0, in_ready=1, out_sum=0 immediately. No stale result appears after release.
- With CLA_STAGE_TXN_COUNT_EN defined, 5 output transfers -> txn_count=5. After a reset, txn_count=0.
